// File: rtl/water_led_pkg.sv
// Shared encodings for the running-light controller: scan modes and ping-pong direction.
package water_led_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Enable-gated prescaler: counts 0..CNT_MAX-1 and flags the last count of each period.
module led_prescaler #(
    parameter int unsigned CNT_MAX = 24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

    logic [CW-1:0] cnt;

    // Count is held, not cleared, while disabled so a paused period resumes where it stopped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/water_led_ctrl.sv
// Running-light (water LED) controller: one lit LED stepped up, down, ping-pong or held on each prescaler tick.
module water_led_ctrl
    import water_led_pkg::*;
#(
    parameter int unsigned LED_NUM     = 4,
    parameter int unsigned CNT_MAX     = 24_999_999,
    parameter int unsigned LED_ACT_LOW = 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    output logic [LED_NUM-1:0]         led_out,
    output logic                       step,
    output logic [$clog2(LED_NUM)-1:0] pos
);

    localparam int unsigned PW = $clog2(LED_NUM);
    localparam logic [PW-1:0] LAST_POS = PW'(LED_NUM - 1);
    localparam logic ACT_LVL = (LED_ACT_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [LED_NUM-1:0] LED_ONE = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] LED_RST = (LED_ACT_LOW != 0) ? ~LED_ONE : LED_ONE;

    logic          tick;
    logic          in_pp;
    dir_e          dir;
    dir_e          dir_nxt;
    dir_e          eff_dir;
    logic [PW-1:0] pos_nxt;
    logic [LED_NUM-1:0] led_nxt;

    led_prescaler #(
        .CNT_MAX (CNT_MAX)
    ) u_prescaler (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .tick    (tick)
    );

    // Endpoints force the direction; otherwise a fresh ping-pong entry starts upward and
    // a continuing sweep keeps its stored direction.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        eff_dir = DIR_UP;
        unique case (mode_e'(mode))
            MODE_UP:   pos_nxt = (pos == LAST_POS) ? '0 : pos + PW'(1);
            MODE_DOWN: pos_nxt = (pos == '0) ? LAST_POS : pos - PW'(1);
            MODE_PINGPONG: begin
                if (pos == LAST_POS)  eff_dir = DIR_DOWN;
                else if (pos == '0)   eff_dir = DIR_UP;
                else if (in_pp)       eff_dir = dir;
                else                  eff_dir = DIR_UP;
                if (eff_dir == DIR_UP) begin
                    pos_nxt = pos + PW'(1);
                    dir_nxt = (pos == LAST_POS - PW'(1)) ? DIR_DOWN : DIR_UP;
                end else begin
                    pos_nxt = pos - PW'(1);
                    dir_nxt = (pos == PW'(1)) ? DIR_UP : DIR_DOWN;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        led_nxt = '0;
        for (int unsigned i = 0; i < LED_NUM; i++) begin
            led_nxt[i] = (pos_nxt == PW'(i)) ? ACT_LVL : ~ACT_LVL;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pos     <= '0;
            dir     <= DIR_UP;
            in_pp   <= 1'b0;
            step    <= 1'b0;
            led_out <= LED_RST;
        end else begin
            step <= tick && (mode != MODE_HOLD);
            if (tick) begin
                pos     <= pos_nxt;
                dir     <= dir_nxt;
                in_pp   <= (mode == MODE_PINGPONG);
                led_out <= led_nxt;
            end
        end
    end

endmodule
